// File: rtl/fir_sequencer.sv
// ---------------------------------------------------------------------------
// fir_sequencer
//
// Control sequencer for one FIR output sample. For each sample it pops the
// input FIFO, shifts the coefficient/sample memory, waits for the MAC to
// finish, then presents the accumulated result downstream.
//
// Ports
//   clk, reset     : single rising-edge clock, synchronous active-high reset
//   enable         : level run request
//   fifo_empty     : input sample FIFO empty flag
//   mac_done       : MAC completion level flag
//   mac_result     : MAC accumulator value (RESULT_W bits)
//   read_enable    : one-cycle FIFO pop strobe
//   shift_enable   : one-cycle memory shift strobe
//   out_data       : captured filter result (RESULT_W bits)
//   out_valid      : out_data is valid
//   out_ready      : downstream accepts out_data
//   sample_count   : completed outputs, wraps modulo 2^16
//   busy           : FSM is in any state other than IDLE
//   timeout_err    : sticky flag, a MAC wait exceeded MAC_TIMEOUT cycles
//   state_dbg      : current FSM state (IDLE=0 READ=1 SHIFT=2 WAIT_MAC=3
//                    OUTPUT=4)
//
// Output handshake: out_valid/out_data are held stable while out_valid=1 and
// out_ready=0, for any number of cycles. A transfer happens on the rising
// edge where out_valid=1 and out_ready=1; out_valid drops on the next cycle
// and sample_count advances by one on that same edge.
// ---------------------------------------------------------------------------
module fir_sequencer #(
  parameter int RESULT_W    = 32,
  parameter int MAC_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic                mac_done,
  input  logic [RESULT_W-1:0] mac_result,
  output logic                read_enable,
  output logic                shift_enable,
  output logic [RESULT_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         sample_count,
  output logic                busy,
  output logic                timeout_err,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_WAIT_MAC = 3'd3,
    ST_OUTPUT   = 3'd4
  } state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(MAC_TIMEOUT);

  state_e                state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  done_prev_q, done_prev_d;
  logic [RESULT_W-1:0]   out_data_q, out_data_d;
  logic [15:0]           sample_count_q, sample_count_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  start_ok;
  logic                  mac_rise;
  logic [7:0]            wait_cnt_inc;

  // A new sample may begin only when running and the FIFO has data.
  assign start_ok     = enable & ~fifo_empty;
  // Completion is the rising edge of mac_done; a level left high from an
  // earlier operation is masked by done_prev_q captured in SHIFT.
  assign mac_rise     = mac_done & ~done_prev_q;
  assign wait_cnt_inc = wait_cnt_q + 8'd1;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    done_prev_d    = done_prev_q;
    out_data_d     = out_data_q;
    sample_count_d = sample_count_q;
    timeout_err_d  = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_READ;
      end

      ST_READ: begin
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        wait_cnt_d  = 8'd0;
        done_prev_d = mac_done;
        state_d     = ST_WAIT_MAC;
      end

      ST_WAIT_MAC: begin
        wait_cnt_d  = wait_cnt_inc;
        done_prev_d = mac_done;
        // Completion is checked first so it wins over a simultaneous timeout.
        if (mac_rise) begin
          out_data_d = mac_result;
          state_d    = ST_OUTPUT;
        end else if (wait_cnt_inc == TIMEOUT_LIM) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_OUTPUT: begin
        if (out_ready) begin
          sample_count_d = sample_count_q + 16'd1;
          state_d        = start_ok ? ST_READ : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= 8'd0;
      done_prev_q    <= 1'b0;
      out_data_q     <= '0;
      sample_count_q <= 16'd0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      done_prev_q    <= done_prev_d;
      out_data_q     <= out_data_d;
      sample_count_q <= sample_count_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // Strobes and status are pure decodes of the registered state, so
  // read_enable and shift_enable can never overlap.
  assign read_enable  = (state_q == ST_READ);
  assign shift_enable = (state_q == ST_SHIFT);
  assign out_valid    = (state_q == ST_OUTPUT);
  assign busy         = (state_q != ST_IDLE);
  assign out_data     = out_data_q;
  assign sample_count = sample_count_q;
  assign timeout_err  = timeout_err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_sequencer
//
// Scoreboard bench for fir_sequencer (MAC_TIMEOUT=8). A MAC responder reacts
// to each shift strobe with a planned mac_done waveform and pushes the value
// the sequencer must deliver; a monitor pops and compares on every output
// transfer and tracks the expected sample count and strobe sequence.
// ---------------------------------------------------------------------------
module tb_fir_sequencer;

  localparam int RESULT_W    = 32;
  localparam int MAC_TIMEOUT = 8;

  // Plan kinds for the MAC responder.
  localparam int K_NORMAL  = 0;
  localparam int K_TIMEOUT = 1;
  localparam int K_STALE   = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic                fifo_empty;
  logic                mac_done;
  logic [RESULT_W-1:0] mac_result;
  logic                read_enable;
  logic                shift_enable;
  logic [RESULT_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [15:0]         sample_count;
  logic                busy;
  logic                timeout_err;
  logic [2:0]          state_dbg;

  fir_sequencer #(
    .RESULT_W    (RESULT_W),
    .MAC_TIMEOUT (MAC_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .mac_done     (mac_done),
    .mac_result   (mac_result),
    .read_enable  (read_enable),
    .shift_enable (shift_enable),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sample_count (sample_count),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int                  n_vec = 0;
  int                  n_err = 0;
  logic [RESULT_W-1:0] exp_q[$];
  logic [15:0]         exp_cnt;
  logic                exp_terr;
  int                  ready_pct;
  logic                quick_mode;
  logic                fp_valid;
  int                  fp_kind;
  int                  fp_d;
  logic [31:0]         fp_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (main drives 2 units after posedge) ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_plan(input int kind, input int d, input logic [31:0] val);
    fp_kind  = kind;
    fp_d     = d;
    fp_val   = val;
    fp_valid = 1'b1;
  endtask

  // One-cycle run request: the FSM must start and finish the sample anyway.
  task automatic start_one();
    enable     = 1'b1;
    fifo_empty = 1'b0;
    tick();
    enable     = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: busy=1 after %0d cycles, expected busy=0", name, max_cyc);
    end
  endtask

  // which: 0 = shift_enable, 1 = out_valid
  task automatic wait_for(input int which, input int max_cyc, input string name);
    int n = 0;
    while (((which == 0) ? !shift_enable : !out_valid) && n < max_cyc) begin
      tick();
      n++;
    end
    if ((which == 0) ? !shift_enable : !out_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: event not seen within %0d cycles, expected it", name, max_cyc);
    end
  endtask

  // ---------------- MAC responder ----------------
  // Negedge k after the SHIFT negedge (k=0) drives the mac_done level the
  // sequencer sees in its k-th WAIT_MAC cycle.
  task automatic run_plan();
    int          kind;
    int          d;
    int          s;
    int          g;
    int          r;
    logic [31:0] val;
    if (fp_valid) begin
      kind     = fp_kind;
      d        = fp_d;
      val      = fp_val;
      s        = 0;
      g        = 2;
      fp_valid = 1'b0;
    end else begin
      val = $urandom;
      s   = int'($urandom_range(0, 2));
      g   = int'($urandom_range(1, 3));
      if (quick_mode) begin
        kind = K_NORMAL;
        d    = int'($urandom_range(1, 3));
      end else begin
        r    = int'($urandom_range(0, 99));
        kind = (r < 60) ? K_NORMAL : (r < 80) ? K_STALE : K_TIMEOUT;
        r    = int'($urandom_range(0, 3));
        d    = (r == 0) ? 1 : (r == 1) ? MAC_TIMEOUT : int'($urandom_range(1, MAC_TIMEOUT));
      end
    end
    if (kind == K_STALE) d = s + g + 1;

    mac_done   = (kind == K_STALE);
    mac_result = ~val;
    for (int k = 1; k <= MAC_TIMEOUT + 1; k++) begin
      @(negedge clk);
      if (reset) begin
        mac_done = 1'b0;
        return;
      end
      if (k == MAC_TIMEOUT + 1) begin
        exp_terr = 1'b1;
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        check("timeout_to_idle", 32'(busy), 32'd0);
        check("timeout_no_valid", 32'(out_valid), 32'd0);
        return;
      end
      if (kind != K_TIMEOUT && k == d) begin
        mac_done   = 1'b1;
        mac_result = val;
        exp_q.push_back(val);
        @(negedge clk);
        if (reset) return;
        check("valid_after_done", 32'(out_valid), 32'd1);
        check("timeout_err_level", 32'(timeout_err), 32'(exp_terr));
        return;
      end
      mac_done = (kind == K_STALE) && (k <= s);
    end
  endtask

  initial begin : responder
    mac_done   = 1'b0;
    mac_result = '0;
    forever begin
      @(negedge clk);
      if (!reset && shift_enable) run_plan();
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic rd_exp;
    logic sh_exp;
    logic hs_prev;
    logic post_reset;
    logic hs;
    rd_exp     = 1'b0;
    sh_exp     = 1'b0;
    hs_prev    = 1'b0;
    post_reset = 1'b0;
    out_ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        exp_cnt    = 16'd0;
        exp_terr   = 1'b0;
        post_reset = 1'b1;
        hs_prev    = 1'b0;
        rd_exp     = 1'b0;
        sh_exp     = 1'b0;
        out_ready  = 1'b0;
      end else begin
        if (post_reset) begin
          check("rst_state", 32'(state_dbg), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_read_enable", 32'(read_enable), 32'd0);
          check("rst_shift_enable", 32'(shift_enable), 32'd0);
          check("rst_out_valid", 32'(out_valid), 32'd0);
          check("rst_out_data", out_data, 32'd0);
          check("rst_sample_count", 32'(sample_count), 32'd0);
          check("rst_timeout_err", 32'(timeout_err), 32'd0);
          post_reset = 1'b0;
        end else begin
          check("sample_count", 32'(sample_count), 32'(exp_cnt));
          check("read_enable", 32'(read_enable), 32'(rd_exp));
          check("shift_enable", 32'(shift_enable), 32'(sh_exp));
          if (hs_prev) check("valid_drop", 32'(out_valid), 32'd0);
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got out_data 0x%0h, expected no output at %0t", out_data, $time);
          end else begin
            check("out_data", out_data, exp_q[0]);
          end
        end
        out_ready = (int'($urandom_range(0, 99)) < ready_pct);
        hs        = out_valid && out_ready;
        if (hs && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          exp_cnt = exp_cnt + 16'd1;
        end
        // From IDLE, or on a transfer, the next cycle is READ exactly when
        // running with a non-empty FIFO; READ is always followed by SHIFT.
        rd_exp  = (!busy || hs) && enable && !fifo_empty;
        sh_exp  = read_enable;
        hs_prev = hs;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin : main
    reset      = 1'b1;
    enable     = 1'b0;
    fifo_empty = 1'b1;
    ready_pct  = 100;
    fp_valid   = 1'b0;
    fp_kind    = 0;
    fp_d       = 0;
    fp_val     = 32'd0;
    quick_mode = 1'b0;
    exp_cnt    = 16'd0;
    exp_terr   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single sample, done 3 cycles after SHIFT.
    set_plan(K_NORMAL, 3, 32'h0000_1234);
    start_one();
    wait_idle(40, "single_sample");

    // Backpressure: hold the output stalled for 10+ cycles.
    ready_pct = 0;
    set_plan(K_NORMAL, 2, $urandom);
    start_one();
    wait_for(1, 40, "bp_valid");
    repeat (10) tick();
    ready_pct = 100;
    wait_idle(40, "backpressure");

    // Stale done: high through SHIFT, low for 2, then the real rise.
    set_plan(K_STALE, 0, $urandom);
    start_one();
    wait_idle(40, "stale_done");

    // Completion on the last permitted WAIT_MAC cycle beats the timeout.
    set_plan(K_NORMAL, MAC_TIMEOUT, $urandom);
    start_one();
    wait_idle(40, "done_at_limit");

    // Timeout, then a normal sample with the sticky flag still set.
    set_plan(K_TIMEOUT, 0, 32'd0);
    start_one();
    wait_idle(40, "timeout");
    set_plan(K_NORMAL, 4, $urandom);
    start_one();
    wait_idle(40, "after_timeout");

    // Randomized run: enable, FIFO state, backpressure and MAC behaviour.
    ready_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 9) < 8);
      fifo_empty = ($urandom_range(0, 3) == 0);
      tick();
    end
    enable = 1'b0;
    wait_idle(200, "random_drain");

    // Counter wrap with back-to-back samples from a preset count.
    ready_pct  = 100;
    fifo_empty = 1'b0;
    force dut.sample_count_q = 16'hFFFD;
    exp_cnt = 16'hFFFD;
    tick();
    tick();
    release dut.sample_count_q;
    quick_mode = 1'b1;
    enable     = 1'b1;
    begin
      int n = 0;
      while (exp_cnt != 16'h0001 && n < 200) begin
        tick();
        n++;
      end
      check("wrap_reached", 32'(exp_cnt), 32'h0001);
    end
    enable = 1'b0;
    wait_idle(40, "wrap_drain");
    quick_mode = 1'b0;

    // Reset while waiting for the MAC.
    set_plan(K_TIMEOUT, 0, 32'd0);
    enable     = 1'b1;
    fifo_empty = 1'b0;
    wait_for(0, 20, "rst_wait_shift");
    enable = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Reset while an output is pending.
    ready_pct = 0;
    set_plan(K_NORMAL, 2, $urandom);
    enable     = 1'b1;
    fifo_empty = 1'b0;
    wait_for(1, 20, "rst_out_valid");
    enable = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ready_pct = 100;
    tick();

    // Operation resumes after reset.
    set_plan(K_NORMAL, 1, $urandom);
    start_one();
    wait_idle(40, "post_reset_sample");
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
